// File: rtl/core_pkg.sv
// Shared types for the 11-bit-PC core: PC type, PC mux selects, reset vector
// and the interrupt controller state encoding.
package core_pkg;

  typedef logic [10:0] pc_t;

  typedef enum logic [1:0] {
    PC_SEL_NEXT   = 2'h0,
    PC_SEL_BRANCH = 2'h1,
    PC_SEL_JUMP   = 2'h2,
    PC_SEL_SAVE   = 2'h3
  } pc_sel_t;

  localparam pc_t RESET_VECTOR = 11'h000;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } irq_state_t;

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: the lowest-numbered asserted request wins.
module irq_priority_enc #(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [ID_W-1:0]    sel_id,
  output logic               req_any
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) sel_id = ID_W'(i);
    end
  end

  assign req_any = |req;

endmodule

// File: rtl/interrupt_vectored.sv
// Vectored interrupt controller between the PC mux and the PC register:
// fixed-priority, per-source vectors, edge/level sources and runtime enables.
module interrupt_vectored #(
  parameter int                NUM_IRQ       = 4,
  parameter int                PC_W          = 11,
  parameter logic [PC_W-1:0]    VECTOR_BASE   = 11'h004,
  parameter logic [PC_W-1:0]    VECTOR_STRIDE = 11'h002,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK     = 4'b0011,
  parameter logic [NUM_IRQ-1:0] ENABLE_RESET  = 4'b1111,
  parameter logic [1:0]         PC_SEL_SAVE   = 2'h3,
  localparam int               ID_W          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               instr_valid,
  input  logic [1:0]         pc_mux_control,
  input  logic [PC_W-1:0]    pc_next,
  input  logic               en_we,
  input  logic [NUM_IRQ-1:0] en_wdata,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_save,
  output logic [ID_W-1:0]    active_id,
  output logic               in_isr,
  output logic [NUM_IRQ-1:0] enable
);

  import core_pkg::irq_state_t;
  import core_pkg::IDLE;
  import core_pkg::ACTIVE;
  import core_pkg::RESET_VECTOR;

  irq_state_t         state_q;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] enable_q;
  logic [NUM_IRQ-1:0] req;
  logic [PC_W-1:0]    pc_save_q;
  logic [PC_W-1:0]    vec;
  logic [ID_W-1:0]    active_id_q;
  logic [ID_W-1:0]    sel_id;
  logic               in_isr_q;
  logic               req_any;
  logic               take;
  logic               rfi;

  // Edge sources request from their latched bit, level sources straight from the pin.
  assign req = ((EDGE_MASK & pending_q) | (~EDGE_MASK & irq)) & enable_q;

  irq_priority_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio (
    .req     (req),
    .sel_id  (sel_id),
    .req_any (req_any)
  );

  assign vec  = VECTOR_BASE + PC_W'(sel_id) * VECTOR_STRIDE;
  assign take = (state_q == IDLE) && instr_valid && req_any;
  assign rfi  = (state_q == ACTIVE) && instr_valid && (pc_mux_control == PC_SEL_SAVE);

  // A fresh edge on the same cycle as the entry clear keeps the bit set.
  always_comb begin
    pending_d = pending_q;
    if (take && EDGE_MASK[sel_id]) pending_d[sel_id] = 1'b0;
    pending_d = pending_d | (irq & ~irq_q & EDGE_MASK);
  end

  assign pc_out    = (reset_n && take) ? vec : pc_next;
  assign pc_save   = pc_save_q;
  assign active_id = active_id_q;
  assign in_isr    = in_isr_q;
  assign enable    = enable_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      irq_q       <= '0;
      pending_q   <= '0;
      enable_q    <= ENABLE_RESET;
      pc_save_q   <= PC_W'(RESET_VECTOR);
      active_id_q <= '0;
      in_isr_q    <= 1'b0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      if (en_we) enable_q <= en_wdata;
      case (state_q)
        IDLE: begin
          if (take) begin
            state_q     <= ACTIVE;
            pc_save_q   <= pc_next;
            active_id_q <= sel_id;
            in_isr_q    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (rfi) begin
            state_q  <= IDLE;
            in_isr_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          in_isr_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_vectored.sv
// Directed bench for interrupt_vectored: default instance plus a wrapped-vector instance.
module tb_interrupt_vectored;

  logic        clk;
  logic        reset_n;
  logic [3:0]  irq;
  logic        instr_valid;
  logic [1:0]  pc_mux_control;
  logic [10:0] pc_next;
  logic        en_we;
  logic [3:0]  en_wdata;
  logic [10:0] pc_out;
  logic [10:0] pc_save;
  logic [1:0]  active_id;
  logic        in_isr;
  logic [3:0]  enable;

  logic [3:0]  irq2;
  logic        instr_valid2;
  logic [10:0] pc_out2;
  logic [10:0] pc_save2;
  logic [1:0]  active_id2;
  logic        in_isr2;
  logic [3:0]  enable2;

  int checks;
  int errors;

  interrupt_vectored dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .irq            (irq),
    .instr_valid    (instr_valid),
    .pc_mux_control (pc_mux_control),
    .pc_next        (pc_next),
    .en_we          (en_we),
    .en_wdata       (en_wdata),
    .pc_out         (pc_out),
    .pc_save        (pc_save),
    .active_id      (active_id),
    .in_isr         (in_isr),
    .enable         (enable)
  );

  interrupt_vectored #(
    .VECTOR_BASE   (11'h7FE),
    .VECTOR_STRIDE (11'h002)
  ) dut2 (
    .clk            (clk),
    .reset_n        (reset_n),
    .irq            (irq2),
    .instr_valid    (instr_valid2),
    .pc_mux_control (pc_mux_control),
    .pc_next        (pc_next),
    .en_we          (1'b0),
    .en_wdata       (4'h0),
    .pc_out         (pc_out2),
    .pc_save        (pc_save2),
    .active_id      (active_id2),
    .in_isr         (in_isr2),
    .enable         (enable2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] i, input logic iv, input logic [1:0] sel,
                               input logic [10:0] pcn);
    irq            = i;
    instr_valid    = iv;
    pc_mux_control = sel;
    pc_next        = pcn;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0; irq = '0; instr_valid = 1'b0; pc_mux_control = 2'h0;
    pc_next = 11'h040; en_we = 1'b0; en_wdata = '0; irq2 = '0; instr_valid2 = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("rst_in_isr", in_isr, 0);
    checkOutput("rst_pc_save", pc_save, 0);
    checkOutput("rst_active_id", active_id, 0);
    checkOutput("rst_enable", enable, 4'hF);
    checkOutput("rst_pc_out", pc_out, 11'h040);
    reset_n = 1'b1;
    nextCycle();

    $display("[TB] edge entry on source 1");
    applyStimulus(4'b0010, 0, 2'h0, 11'h040);
    nextCycle();
    applyStimulus(4'b0000, 1, 2'h0, 11'h040);
    checkOutput("t1_vec", pc_out, 11'h006);
    nextCycle();
    applyStimulus(4'b0001, 0, 2'h0, 11'h040);
    checkOutput("t1_pc_save", pc_save, 11'h040);
    checkOutput("t1_active_id", active_id, 1);
    checkOutput("t1_in_isr", in_isr, 1);
    nextCycle();
    applyStimulus(4'b0000, 1, 2'h0, 11'h041);
    checkOutput("t1_no_nest", pc_out, 11'h041);
    nextCycle();
    checkOutput("t1_still_isr", in_isr, 1);
    applyStimulus(4'b0000, 1, 2'h3, 11'h040);
    checkOutput("t1_rfi_pc", pc_out, 11'h040);
    nextCycle();
    checkOutput("t1_rfi_idle", in_isr, 0);
    applyStimulus(4'b0000, 1, 2'h0, 11'h041);
    checkOutput("t1_tail_vec", pc_out, 11'h004);
    nextCycle();
    checkOutput("t1_tail_id", active_id, 0);
    checkOutput("t1_tail_save", pc_save, 11'h041);
    applyStimulus(4'b0000, 1, 2'h3, 11'h041);
    nextCycle();
    applyStimulus(4'b0000, 1, 2'h0, 11'h042);
    checkOutput("t1_pend1_cleared", pc_out, 11'h042);
    nextCycle();
    checkOutput("t1_idle", in_isr, 0);

    $display("[TB] simultaneous sources 0 and 3");
    applyStimulus(4'b1001, 0, 2'h0, 11'h050);
    nextCycle();
    applyStimulus(4'b1000, 1, 2'h0, 11'h050);
    checkOutput("t2_src0_wins", pc_out, 11'h004);
    nextCycle();
    checkOutput("t2_id0", active_id, 0);
    applyStimulus(4'b1000, 1, 2'h3, 11'h050);
    checkOutput("t2_rfi_pc", pc_out, 11'h050);
    nextCycle();
    applyStimulus(4'b1000, 1, 2'h0, 11'h051);
    checkOutput("t2_src3_vec", pc_out, 11'h00A);
    nextCycle();
    checkOutput("t2_id3", active_id, 3);
    checkOutput("t2_save", pc_save, 11'h051);

    $display("[TB] level source 3 dropped and held");
    applyStimulus(4'b0000, 0, 2'h0, 11'h051);
    nextCycle();
    applyStimulus(4'b0000, 1, 2'h3, 11'h051);
    nextCycle();
    applyStimulus(4'b0000, 1, 2'h0, 11'h052);
    checkOutput("t3_no_reentry", pc_out, 11'h052);
    nextCycle();
    checkOutput("t3_idle", in_isr, 0);
    applyStimulus(4'b1000, 1, 2'h0, 11'h060);
    checkOutput("t3_level_vec", pc_out, 11'h00A);
    nextCycle();
    applyStimulus(4'b1000, 1, 2'h3, 11'h060);
    checkOutput("t3_rfi_pc", pc_out, 11'h060);
    nextCycle();
    checkOutput("t3_rfi_idle", in_isr, 0);
    applyStimulus(4'b1000, 1, 2'h0, 11'h061);
    checkOutput("t3_reentry_vec", pc_out, 11'h00A);
    nextCycle();
    checkOutput("t3_reentry_isr", in_isr, 1);
    checkOutput("t3_reentry_save", pc_save, 11'h061);
    applyStimulus(4'b0000, 1, 2'h3, 11'h061);
    nextCycle();
    applyStimulus(4'b0000, 0, 2'h0, 11'h061);

    $display("[TB] enable mask");
    en_we = 1'b1; en_wdata = 4'b1101;
    nextCycle();
    en_we = 1'b0;
    checkOutput("t4_enable_d", enable, 4'hD);
    applyStimulus(4'b0010, 0, 2'h0, 11'h070);
    nextCycle();
    applyStimulus(4'b0000, 1, 2'h0, 11'h070);
    checkOutput("t4_masked", pc_out, 11'h070);
    nextCycle();
    checkOutput("t4_masked_idle", in_isr, 0);
    en_we = 1'b1; en_wdata = 4'b1111;
    applyStimulus(4'b0000, 1, 2'h0, 11'h071);
    checkOutput("t4_old_mask", pc_out, 11'h071);
    nextCycle();
    en_we = 1'b0;
    checkOutput("t4_enable_f", enable, 4'hF);
    applyStimulus(4'b0000, 1, 2'h0, 11'h072);
    checkOutput("t4_unmasked_vec", pc_out, 11'h006);
    nextCycle();
    checkOutput("t4_id1", active_id, 1);
    applyStimulus(4'b0000, 1, 2'h3, 11'h072);
    nextCycle();

    $display("[TB] edge set wins over entry clear");
    applyStimulus(4'b0010, 0, 2'h0, 11'h080);
    nextCycle();
    applyStimulus(4'b0000, 0, 2'h0, 11'h080);
    nextCycle();
    applyStimulus(4'b0010, 1, 2'h0, 11'h080);
    checkOutput("t7_vec", pc_out, 11'h006);
    nextCycle();
    applyStimulus(4'b0000, 1, 2'h3, 11'h080);
    nextCycle();
    applyStimulus(4'b0000, 1, 2'h0, 11'h081);
    checkOutput("t7_set_wins", pc_out, 11'h006);
    nextCycle();
    checkOutput("t7_isr", in_isr, 1);

    $display("[TB] reset mid-ISR");
    applyStimulus(4'b0001, 0, 2'h0, 11'h081);
    nextCycle();
    applyStimulus(4'b0000, 0, 2'h0, 11'h081);
    nextCycle();
    reset_n = 1'b0;
    applyStimulus(4'b0000, 1, 2'h0, 11'h090);
    checkOutput("t6_rst_pc_out", pc_out, 11'h090);
    nextCycle();
    checkOutput("t6_in_isr", in_isr, 0);
    checkOutput("t6_pc_save", pc_save, 0);
    checkOutput("t6_active_id", active_id, 0);
    reset_n = 1'b1;
    applyStimulus(4'b0000, 0, 2'h0, 11'h090);
    nextCycle();
    applyStimulus(4'b0000, 1, 2'h0, 11'h091);
    checkOutput("t6_pending_dropped", pc_out, 11'h091);
    nextCycle();
    checkOutput("t6_idle", in_isr, 0);
    applyStimulus(4'b0000, 0, 2'h0, 11'h091);

    $display("[TB] vector wrap");
    irq2 = 4'b0100; instr_valid2 = 1'b1;
    #1;
    checkOutput("t5_wrap_vec", pc_out2, 11'h002);
    nextCycle();
    checkOutput("t5_wrap_id", active_id2, 2);
    checkOutput("t5_wrap_isr", in_isr2, 1);
    irq2 = '0; instr_valid2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
